// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller with tag/valid arrays.
// Optional DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_controller #(
  parameter int ADDR_WIDTH  = 10,
  parameter int INDEX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  output logic                   stall,
  output logic                   hit,
  output logic [INDEX_WIDTH-1:0] cache_index,
  output logic [1:0]             cache_offset,
  output logic                   cache_refill_we,
  output logic                   cache_word_we,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
`endif
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE_THROUGH} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_WIDTH-1:0]    tag_q [LINES];

  logic [TAG_WIDTH-1:0]    cpu_tag, q_tag;
  logic [INDEX_WIDTH-1:0]  cpu_idx, q_idx;
  logic                    idle;

  assign cpu_tag = cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign cpu_idx = cpu_addr[INDEX_WIDTH+1:2];
  assign q_tag   = addr_q[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign q_idx   = addr_q[INDEX_WIDTH+1:2];
  assign idle    = (state_q == IDLE);

  assign hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (cpu_write) begin
          addr_d  = cpu_addr;
          state_d = WRITE_THROUGH;
        end else if (cpu_read && !hit) begin
          addr_d  = cpu_addr;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_ready) begin
          valid_d[q_idx] = 1'b1;
          state_d        = IDLE;
        end
      end
      WRITE_THROUGH: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // Tags need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (cache_refill_we) tag_q[q_idx] <= q_tag;
  end

  assign cache_index     = idle ? cpu_idx : q_idx;
  assign cache_offset    = idle ? cpu_addr[1:0] : addr_q[1:0];
  assign mem_read        = (state_q == REFILL);
  assign mem_write       = (state_q == WRITE_THROUGH);
  assign mem_addr        = mem_read ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : addr_q;
  assign cache_refill_we = mem_read && mem_ready;
  assign cache_word_we   = !reset && idle && cpu_write && hit;

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:          stall = !reset && (cpu_write || (cpu_read && !hit));
      REFILL:        stall = 1'b1;
      WRITE_THROUGH: stall = !mem_ready;
      default:       stall = 1'b0;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (idle && (cpu_read || cpu_write)) begin
      if (hit) begin
        if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
      end else begin
        if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized self-checking bench for dcache_controller against a tag/valid array model.
// Build with DCACHE_STATS_EN to also check the hit/miss counters.
module tb_dcache_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_read, cpu_write;
  logic [9:0] cpu_addr;
  logic       stall, hit;
  logic [4:0] cache_index;
  logic [1:0] cache_offset;
  logic       cache_refill_we, cache_word_we;
  logic       mem_read, mem_write;
  logic [9:0] mem_addr;
  logic       mem_ready;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  bit       mvalid [32];
  bit [2:0] mtag   [32];
  int       exp_hits = 0;
  int       exp_miss = 0;

  always #5 clk = ~clk;

  dcache_controller #(.ADDR_WIDTH(10), .INDEX_WIDTH(5)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .stall(stall), .hit(hit),
    .cache_index(cache_index), .cache_offset(cache_offset),
    .cache_refill_we(cache_refill_we), .cache_word_we(cache_word_we),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit model_hit(input logic [9:0] a);
    return mvalid[a[6:2]] && (mtag[a[6:2]] == a[9:7]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
  endtask

  // One CPU request, with lat waiting cycles before mem_ready when memory is involved.
  task automatic do_req(input bit wr, input logic [9:0] a, input int lat);
    bit         exp_hit;
    logic [9:0] exp_maddr;
    @(posedge clk); #1;
    cpu_addr = a; cpu_write = wr; cpu_read = !wr; mem_ready = 1'b0;
    exp_hit   = model_hit(a);
    exp_maddr = wr ? a : {a[9:2], 2'b00};
    @(negedge clk);
    $display("req %s addr=%03h expect_hit=%0d lat=%0d", wr ? "WR" : "RD", a, exp_hit, lat);
    chk("hit", 32'(hit), 32'(exp_hit));
    chk("idle_index", 32'(cache_index), 32'(a[6:2]));
    chk("idle_offset", 32'(cache_offset), 32'(a[1:0]));
    chk("idle_memrd", 32'(mem_read | mem_write), 32'd0);
    if (wr) begin
      chk("word_we", 32'(cache_word_we), 32'(exp_hit));
      chk("stall_wr", 32'(stall), 32'd1);
    end else begin
      chk("stall_rd", 32'(stall), 32'(!exp_hit));
      chk("word_we_rd", 32'(cache_word_we), 32'd0);
    end
    if (exp_hit) exp_hits++; else exp_miss++;

    if (!wr && exp_hit) begin
      @(posedge clk); #1;
      cpu_read = 1'b0;
    end else begin
      for (int i = 0; i < lat; i++) begin
        @(posedge clk); #1;
        cpu_addr = 10'($urandom);
        @(negedge clk);
        chk("wait_memrd", 32'(mem_read), 32'(!wr));
        chk("wait_memwr", 32'(mem_write), 32'(wr));
        chk("wait_maddr", 32'(mem_addr), 32'(exp_maddr));
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_we", 32'({cache_refill_we, cache_word_we}), 32'd0);
        chk("wait_index", 32'(cache_index), 32'(a[6:2]));
      end
      @(posedge clk); #1;
      cpu_addr = a; mem_ready = 1'b1;
      @(negedge clk);
      chk("rdy_refill_we", 32'(cache_refill_we), 32'(!wr));
      chk("rdy_stall", 32'(stall), 32'(!wr));
      chk("rdy_maddr", 32'(mem_addr), 32'(exp_maddr));
      chk("rdy_word_we", 32'(cache_word_we), 32'd0);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (wr) begin
        cpu_write = 1'b0;
      end else begin
        mvalid[a[6:2]] = 1'b1;
        mtag[a[6:2]]   = a[9:7];
        @(negedge clk);
        chk("post_hit", 32'(hit), 32'd1);
        chk("post_stall", 32'(stall), 32'd0);
        chk("post_memrd", 32'(mem_read), 32'd0);
        chk("post_index", 32'(cache_index), 32'(a[6:2]));
        chk("post_offset", 32'(cache_offset), 32'(a[1:0]));
        exp_hits++;
        @(posedge clk); #1;
        cpu_read = 1'b0;
      end
    end
  endtask

  // mem_ready with no outstanding transaction must be ignored.
  task automatic stray_ready();
    @(posedge clk); #1;
    mem_ready = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
    @(negedge clk);
    $display("stray mem_ready in IDLE");
    chk("stray_stall", 32'(stall), 32'd0);
    chk("stray_mem", 32'({mem_read, mem_write, cache_refill_we}), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
  endtask

  task automatic reset_mid_refill(input logic [9:0] a);
    @(posedge clk); #1;
    cpu_addr = a; cpu_read = 1'b1; cpu_write = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    $display("reset during refill of addr=%03h", a);
    chk("mr_memrd", 32'(mem_read), 32'd1);
    #2;
    reset = 1'b1; cpu_read = 1'b0;
    #1;
    chk("mr_memrd_rst", 32'(mem_read), 32'd0);
    chk("mr_stall_rst", 32'(stall), 32'd0);
    chk("mr_refill_rst", 32'(cache_refill_we), 32'd0);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; mem_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem", 32'({mem_read, mem_write, cache_refill_we, cache_word_we}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_hit", 32'(hit), 32'd0);

    do_req(1'b0, 10'h044, 3);
    do_req(1'b0, 10'h047, 0);
    do_req(1'b0, 10'h0C4, 2);
    do_req(1'b0, 10'h0C4, 0);
    do_req(1'b0, 10'h044, 1);
    do_req(1'b1, 10'h045, 3);
    do_req(1'b1, 10'h300, 2);
    do_req(1'b0, 10'h300, 0);
    stray_ready();
    reset_mid_refill(10'h1A8);
    do_req(1'b0, 10'h1A8, 2);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        stray_ready();
      end else begin
        do_req($urandom_range(0, 2) == 0,
               {3'($urandom), 3'b000, 2'($urandom), 2'($urandom)},
               int'($urandom_range(0, 4)));
      end
    end

`ifdef DCACHE_STATS_EN
    @(negedge clk);
    chk("hit_count", 32'(hit_count), 32'(exp_hits));
    chk("miss_count", 32'(miss_count), 32'(exp_miss));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate data-cache controller between the RISC-V load/store stage and the 1024x32 main data memory.
- Holds the tag and valid arrays and detects hits.
- Sequences main-memory block refills and word write-throughs; drives write enables for the external 128-bit-line cache data array.
- Stalls the pipeline while a memory transaction is outstanding.

Parameters:
- ADDR_WIDTH, 10, word address width; TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2.
- INDEX_WIDTH, 5, line index width; 2**INDEX_WIDTH lines of 4 words each. The 2-bit word offset is fixed because memory returns 4-word blocks.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_read  in  1  load request, held until stall low
- cpu_write  in  1  store request, held until stall low
- cpu_addr  in  ADDR_WIDTH  word address
- stall  out  1  pipeline freeze
- hit  out  1  combinational tag match AND valid for cpu_addr
- cache_index  out  INDEX_WIDTH  data-array line select
- cache_offset  out  2  data-array word select
- cache_refill_we  out  1  write the full 128-bit memory block into line cache_index
- cache_word_we  out  1  write cpu store word into cache_index/cache_offset
- mem_read  out  1  main-memory block read, held until mem_ready
- mem_write  out  1  main-memory word write, held until mem_ready
- mem_addr  out  ADDR_WIDTH  main-memory word address
- mem_ready  in  1  one-cycle completion pulse from memory

Behaviour:
- Reset (async): state=IDLE, all valid bits=0, addr_q=0. stall, cache_refill_we, cache_word_we, mem_read and mem_write are all 0. Reset mid-transaction aborts it; the line being refilled stays invalid.
- Address split: tag = addr[ADDR_WIDTH-1 : INDEX_WIDTH+2], index = addr[INDEX_WIDTH+1 : 2], offset = addr[1:0].
- hit = valid[index] && tag_arr[index] == tag of cpu_addr. Computed combinationally in every state.
- States: IDLE, REFILL, WRITE_THROUGH.
- IDLE, cache_index/offset from cpu_addr:
  - cpu_write has priority over cpu_read when both are asserted.
  - cpu_write: stall=1; cache_word_we=hit (single-cycle pulse); addr_q<=cpu_addr; next state WRITE_THROUGH. A write miss does not allocate and leaves valid/tag untouched.
  - cpu_read with hit: stall=0; no state change; zero-wait load.
  - cpu_read with miss: stall=1; addr_q<=cpu_addr; next state REFILL.
  - Neither request: stall=0.
- REFILL, cache_index/offset from addr_q:
  - mem_read=1, mem_addr={addr_q[ADDR_WIDTH-1:2],2'b00}, stall=1.
  - On mem_ready=1: cache_refill_we=1 for that cycle only; at the edge, valid[idx]<=1 and tag_arr[idx]<=tag(addr_q); next state IDLE.
  - The following IDLE cycle hits with stall=0.
- WRITE_THROUGH, cache_index/offset from addr_q:
  - mem_write=1, mem_addr=addr_q.
  - stall = !mem_ready, so the store retires at the edge where mem_ready=1; next state IDLE.
- Memory latency is not fixed. The controller waits on mem_ready only and never counts cycles. mem_read/mem_write are Moore outputs, never both high, and held continuously while waiting.
- mem_ready seen in IDLE is ignored.
- cpu_addr/cpu_read/cpu_write changing during REFILL or WRITE_THROUGH is ignored; addr_q governs.

Optional Feature:
- DCACHE_STATS_EN defined: adds outputs hit_count[15:0] and miss_count[15:0], both reset to 0 and saturating at 16'hFFFF.
  - hit_count increments on each IDLE cycle with (cpu_read or cpu_write) and hit, once per request.
  - miss_count increments on each IDLE cycle entering REFILL, or entering WRITE_THROUGH on a miss.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold read: reset, then cpu_read addr=0x044 → hit=0, stall=1, mem_read=1 with mem_addr=0x044 until mem_ready. cache_refill_we=1 exactly in the mem_ready cycle. Next cycle hit=1, stall=0, cache_index=0x11, cache_offset=0.
- Read hit same line: cpu_read 0x047 after the above → hit=1, stall=0 same cycle, mem_read stays 0.
- Conflict miss: cpu_read 0x0C4 (same index 0x11, tag 1 vs 0) → REFILL. Afterwards 0x0C4 hits and 0x044 misses.
- Write hit: cpu_write 0x045 with line resident → cache_word_we pulse in cycle 0 only; mem_write=1, mem_addr=0x045 held until mem_ready; stall falls in the mem_ready cycle.
- Write miss: cpu_write 0x300 on invalid line → cache_word_we=0, valid unchanged, mem_write completes. A following cpu_read 0x300 misses.
- Reset mid-refill: assert reset during REFILL → mem_read=0 and stall=0 immediately; re-reading the address misses.
